// File: rtl/shift_dot_accum_if.sv
// shift_dot_accum_if
//   Beat and result channels for the shift_dot_accum engine.
//
//   Handshake: a producer holds a transfer stable while its valid is high.
//   The transfer completes on the rising clock edge where valid & ready are
//   both 1. Ready never depends on valid in the same cycle.
//   Input channel:  ivalid / oready, payload ifirst, ilast,
//                   feature_values, filter_values.
//   Output channel: ovalid / iready, payload dot_accum, ovf.
//
//   Modports:
//     master - the upstream/downstream side (drives beats and iready)
//     slave  - the engine (drives oready and the result)
interface shift_dot_accum_if #(
    parameter int LANES  = 16,
    parameter int FEAT_W = 8,
    parameter int WGT_W  = 8,
    parameter int ACC_W  = 32
);
    logic                      ivalid;
    logic                      oready;
    logic                      ifirst;
    logic                      ilast;
    logic [LANES*FEAT_W-1:0]   feature_values;
    logic [LANES*WGT_W-1:0]    filter_values;
    logic                      ovalid;
    logic                      iready;
    logic [ACC_W-1:0]          dot_accum;
    logic                      ovf;

    modport master (
        output ivalid, ifirst, ilast, feature_values, filter_values, iready,
        input  oready, ovalid, dot_accum, ovf
    );

    modport slave (
        input  ivalid, ifirst, ilast, feature_values, filter_values, iready,
        output oready, ovalid, dot_accum, ovf
    );
endinterface

// File: rtl/shift_dot_accum.sv
// shift_dot_accum
//   Pipelined dot product with power-of-two weights. Every lane term is
//   +/-(feature << shift) or zero; the terms are summed by a registered
//   pairwise adder tree and accumulated across a first/last delimited group.
//
//   Pipeline: input register -> decode register -> log2(LANES) tree levels
//   -> accumulator. A beat accepted at edge t produces its result at edge
//   t + log2(LANES) + 2. One global enable (en = ~ovalid | iready) freezes
//   every stage, so a stalled result holds and no beat is lost.
//
//   Ports:
//     clock   rising-edge clock
//     resetn  asynchronous active-low reset
//     bus     shift_dot_accum_if.slave (beat in, result out)
//
//   Weight code per lane: [WGT_W-1] negate, [WGT_W-2] zero, [SHIFT_W-1:0]
//   shift. Any code bits between the shift field and the zero bit are
//   ignored.
module shift_dot_accum #(
    parameter int LANES   = 16,
    parameter int FEAT_W  = 8,
    parameter int WGT_W   = 8,
    parameter int SHIFT_W = 5,
    parameter int ACC_W   = 32
) (
    input logic               clock,
    input logic               resetn,
    shift_dot_accum_if.slave  bus
);
    localparam int LEVELS = $clog2(LANES);
    localparam int NODES  = LANES - 1;

    logic en;
    assign en = ~bus.ovalid | bus.iready;
    assign bus.oready = en;

    // Reserved weight-code bits do not affect the result.
    logic unused_wgt;
    assign unused_wgt = ^bus.filter_values;

    // ---------------------------------------------------------------
    // Input register: capture the beat and split the weight fields.
    // ---------------------------------------------------------------
    logic                in_valid_q;
    logic                in_first_q;
    logic                in_last_q;
    logic [FEAT_W-1:0]   feat_q  [LANES];
    logic [SHIFT_W-1:0]  shift_q [LANES];
    logic [LANES-1:0]    neg_q;
    logic [LANES-1:0]    zero_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            in_valid_q <= 1'b0;
            in_first_q <= 1'b0;
            in_last_q  <= 1'b0;
            neg_q      <= '0;
            zero_q     <= '0;
            for (int i = 0; i < LANES; i++) begin
                feat_q[i]  <= '0;
                shift_q[i] <= '0;
            end
        end else if (en) begin
            in_valid_q <= bus.ivalid;
            in_first_q <= bus.ifirst;
            in_last_q  <= bus.ilast;
            for (int i = 0; i < LANES; i++) begin
                feat_q[i]  <= bus.feature_values[i*FEAT_W +: FEAT_W];
                shift_q[i] <= bus.filter_values[i*WGT_W +: SHIFT_W];
                neg_q[i]   <= bus.filter_values[i*WGT_W + WGT_W - 1];
                zero_q[i]  <= bus.filter_values[i*WGT_W + WGT_W - 2];
            end
        end
    end

    // ---------------------------------------------------------------
    // Decode: each lane works only on its own feature and code.
    // ---------------------------------------------------------------
    logic [ACC_W-1:0] term_d [LANES];

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            term_d[i] = '0;
            if (!zero_q[i]) begin
                term_d[i] = ACC_W'($signed(feat_q[i])) << shift_q[i];
                if (neg_q[i]) begin
                    term_d[i] = -term_d[i];
                end
            end
        end
    end

    logic             d_valid_q;
    logic             d_first_q;
    logic             d_last_q;
    logic [ACC_W-1:0] term_q [LANES];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            d_valid_q <= 1'b0;
            d_first_q <= 1'b0;
            d_last_q  <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                term_q[i] <= '0;
            end
        end else if (en) begin
            d_valid_q <= in_valid_q;
            d_first_q <= in_first_q;
            d_last_q  <= in_last_q;
            for (int i = 0; i < LANES; i++) begin
                term_q[i] <= term_d[i];
            end
        end
    end

    // ---------------------------------------------------------------
    // Adder tree, heap ordered: node n sums children 2n+1 and 2n+2.
    // Child indices >= NODES are decode terms (leaf = index - NODES).
    // Every node is registered, so all leaves reach the root after
    // exactly LEVELS enabled cycles.
    // ---------------------------------------------------------------
    logic [ACC_W-1:0] node_q [NODES];
    logic [ACC_W-1:0] lhs_c  [NODES];
    logic [ACC_W-1:0] rhs_c  [NODES];

    for (genvar n = 0; n < NODES; n++) begin : g_node
        if (2*n + 1 >= NODES) begin : g_lhs_leaf
            assign lhs_c[n] = term_q[2*n + 1 - NODES];
        end else begin : g_lhs_node
            assign lhs_c[n] = node_q[2*n + 1];
        end
        if (2*n + 2 >= NODES) begin : g_rhs_leaf
            assign rhs_c[n] = term_q[2*n + 2 - NODES];
        end else begin : g_rhs_node
            assign rhs_c[n] = node_q[2*n + 2];
        end
    end

    // Sideband travels with the tree; index LEVELS-1 is aligned with the root.
    logic [LEVELS-1:0] tv_q;
    logic [LEVELS-1:0] tf_q;
    logic [LEVELS-1:0] tl_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            tv_q <= '0;
            tf_q <= '0;
            tl_q <= '0;
            for (int n = 0; n < NODES; n++) begin
                node_q[n] <= '0;
            end
        end else if (en) begin
            for (int n = 0; n < NODES; n++) begin
                node_q[n] <= lhs_c[n] + rhs_c[n];
            end
            for (int k = LEVELS - 1; k > 0; k--) begin
                tv_q[k] <= tv_q[k-1];
                tf_q[k] <= tf_q[k-1];
                tl_q[k] <= tl_q[k-1];
            end
            tv_q[0] <= d_valid_q;
            tf_q[0] <= d_first_q;
            tl_q[0] <= d_last_q;
        end
    end

    // ---------------------------------------------------------------
    // Accumulator. A group starts on a first beat or on any beat that
    // follows a last beat (group_done), so a missing ifirst after a
    // completed group or after reset still opens a fresh group.
    // ---------------------------------------------------------------
    logic [ACC_W-1:0] acc_q;
    logic             ovf_q;
    logic             ovalid_q;
    logic             group_done_q;
    logic [ACC_W-1:0] root;
    logic [ACC_W-1:0] acc_sum;
    logic             add_ovf;
    logic             tree_valid;
    logic             tree_start;
    logic             tree_last;

    assign root       = node_q[0];
    assign tree_valid = tv_q[LEVELS-1];
    assign tree_last  = tl_q[LEVELS-1];
    assign tree_start = tf_q[LEVELS-1] | group_done_q;
    assign acc_sum    = acc_q + root;
    // Signed overflow: operands share a sign that the wrapped sum lost.
    assign add_ovf    = (acc_q[ACC_W-1] == root[ACC_W-1]) &&
                        (acc_sum[ACC_W-1] != acc_q[ACC_W-1]);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            acc_q        <= '0;
            ovf_q        <= 1'b0;
            ovalid_q     <= 1'b0;
            group_done_q <= 1'b1;
        end else if (en) begin
            ovalid_q <= tree_valid & tree_last;
            if (tree_valid) begin
                if (tree_start) begin
                    acc_q <= root;
                    ovf_q <= 1'b0;
                end else begin
                    acc_q <= acc_sum;
                    ovf_q <= ovf_q | add_ovf;
                end
                group_done_q <= tree_last;
            end
        end
    end

    assign bus.ovalid    = ovalid_q;
    assign bus.dot_accum = acc_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_shift_dot_accum.sv
module tb_shift_dot_accum;
    localparam int LANES   = 16;
    localparam int FEAT_W  = 8;
    localparam int WGT_W   = 8;
    localparam int SHIFT_W = 5;
    localparam int ACC_W   = 32;
    localparam int FB      = LANES * FEAT_W;
    localparam int WB      = LANES * WGT_W;
    localparam int LAT     = $clog2(LANES) + 2;

    typedef logic [FB-1:0] feat_t;
    typedef logic [WB-1:0] wgt_t;
    typedef struct {
        string            name;
        feat_t            feat;
        wgt_t             wgt;
        logic [ACC_W-1:0] exp_dot;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic resetn = 1'b1;
    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    shift_dot_accum_if #(.LANES(LANES), .FEAT_W(FEAT_W), .WGT_W(WGT_W), .ACC_W(ACC_W)) bus ();

    shift_dot_accum #(
        .LANES(LANES), .FEAT_W(FEAT_W), .WGT_W(WGT_W), .SHIFT_W(SHIFT_W), .ACC_W(ACC_W)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;
    int n_out    = 0;
    logic [ACC_W:0] exp_q[$];
    int unsigned accept_cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    logic             model_done = 1'b1;
    logic [ACC_W-1:0] model_acc  = '0;
    logic             model_ovf  = 1'b0;

    function automatic logic [ACC_W-1:0] beat_sum(input feat_t f, input wgt_t w);
        longint total = 0;
        for (int i = 0; i < LANES; i++) begin
            logic [FEAT_W-1:0] fb;
            logic [WGT_W-1:0]  code;
            longint            fv;
            longint            t;
            fb   = f[i*FEAT_W +: FEAT_W];
            code = w[i*WGT_W +: WGT_W];
            fv   = longint'($signed(fb));
            if (code[WGT_W-2]) t = 0;
            else t = fv * (longint'(1) << code[SHIFT_W-1:0]);
            if (code[WGT_W-1]) t = -t;
            total += t;
        end
        return total[ACC_W-1:0];
    endfunction

    task automatic model_beat(input logic first, input logic last, input logic [ACC_W-1:0] sum);
        longint exact;
        longint lim;
        lim = longint'(1) << (ACC_W - 1);
        if (first || model_done) begin
            model_acc = sum;
            model_ovf = 1'b0;
        end else begin
            exact = longint'($signed(model_acc)) + longint'($signed(sum));
            if (exact >= lim || exact < -lim) model_ovf = 1'b1;
            model_acc = exact[ACC_W-1:0];
        end
        model_done = last;
    endtask

    // ---------------- scoreboard monitor ----------------
    logic           stall_prev = 1'b0;
    logic [ACC_W:0] held = '0;

    always @(negedge clock) begin
        if (resetn) begin
            if (stall_prev && bus.ovalid)
                check("stall_hold", {31'd0, bus.ovf, bus.dot_accum}, {31'd0, held});
            if (bus.ovalid && bus.iready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_result: got 0x%0h, required no result", {bus.ovf, bus.dot_accum});
                end else begin
                    check("result", {31'd0, bus.ovf, bus.dot_accum}, {31'd0, exp_q.pop_front()});
                end
            end
            stall_prev = bus.ovalid && !bus.iready;
            held       = {bus.ovf, bus.dot_accum};
        end else begin
            stall_prev = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle();
        bus.ivalid = 1'b0;
        bus.ifirst = 1'b0;
        bus.ilast  = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Presents one beat and returns at posedge+1 after it is accepted.
    task automatic send_beat(input logic first, input logic last, input feat_t f, input wgt_t w,
                             input logic use_exp, input logic [ACC_W:0] exp_v);
        int waited = 0;
        bus.ivalid = 1'b1;
        bus.ifirst = first;
        bus.ilast  = last;
        bus.feature_values = f;
        bus.filter_values  = w;
        model_beat(first, last, beat_sum(f, w));
        if (last) exp_q.push_back(use_exp ? exp_v : {model_ovf, model_acc});
        forever begin
            @(negedge clock);
            if (bus.oready) break;
            waited++;
            if (waited > 200) begin
                n_checks++;
                $display("FAIL accept_timeout: oready low for %0d cycles, required acceptance", waited);
                break;
            end
        end
        @(posedge clock);
        #1;
        accept_cyc = cyc;
    endtask

    task automatic drain(input string name);
        int k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            @(posedge clock);
            #1;
            k++;
        end
        check(name, exp_q.size(), 0);
    endtask

    function automatic feat_t rep_f(input logic [FEAT_W-1:0] v);
        return {LANES{v}};
    endfunction

    function automatic wgt_t rep_w(input logic [WGT_W-1:0] v);
        return {LANES{v}};
    endfunction

    function automatic feat_t rand_f();
        feat_t f;
        for (int i = 0; i < LANES; i++) f[i*FEAT_W +: FEAT_W] = FEAT_W'($urandom);
        return f;
    endfunction

    function automatic wgt_t rand_w();
        wgt_t w;
        for (int i = 0; i < LANES; i++) w[i*WGT_W +: WGT_W] = WGT_W'($urandom);
        return w;
    endfunction

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    // ---------------- test sequence ----------------
    vec_t tbl[$];
    logic rand_done;

    initial begin
        vec_t             v;
        feat_t            f;
        wgt_t             w;
        logic [ACC_W-1:0] mag;
        int               out0;
        int               k;

        idle();
        bus.iready = 1'b1;
        bus.feature_values = '0;
        bus.filter_values  = '0;

        // Reset state
        #2 resetn = 1'b0;
        #1;
        check("reset_ovalid", bus.ovalid, 0);
        check("reset_dot", bus.dot_accum, 0);
        check("reset_ovf", bus.ovf, 0);
        check("reset_oready", bus.oready, 1);
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        @(posedge clock);
        #1;

        // Vector table: single-beat groups with hand-derived results
        v.name = "ones";       v.feat = rep_f(8'd1);  v.wgt = rep_w(8'h00); v.exp_dot = 32'd16;        tbl.push_back(v);
        v.name = "neg_shift2"; v.feat = rep_f(8'd3);  v.wgt = rep_w(8'h82); v.exp_dot = 32'hFFFFFF40;  tbl.push_back(v);
        v.name = "zero_bit";   v.feat = rep_f(8'd3);  v.wgt = rep_w(8'h42); v.exp_dot = 32'd0;         tbl.push_back(v);
        v.name = "neg_min";    v.feat = rep_f(8'h80); v.wgt = rep_w(8'h80); v.exp_dot = 32'd2048;      tbl.push_back(v);
        f = '0; w = '0;
        f[7*FEAT_W +: FEAT_W] = 8'd5; w[7*WGT_W +: WGT_W] = 8'h01;
        f[0 +: FEAT_W] = 8'd9;        w[0 +: WGT_W] = 8'h80;
        v.name = "lane_iso"; v.feat = f; v.wgt = w; v.exp_dot = 32'd1; tbl.push_back(v);
        f = '0; w = '0;
        f[3*FEAT_W +: FEAT_W] = 8'd1; w[3*WGT_W +: WGT_W] = 8'h1F;
        v.name = "shift31"; v.feat = f; v.wgt = w; v.exp_dot = 32'h80000000; tbl.push_back(v);
        f[3*FEAT_W +: FEAT_W] = 8'h80;
        v.name = "shift31_trunc"; v.feat = f; v.wgt = w; v.exp_dot = 32'd0; tbl.push_back(v);
        for (int i = 0; i < LANES; i++) begin
            f = '0; w = '0;
            f[i*FEAT_W +: FEAT_W] = 8'hFD;
            w[i*WGT_W +: WGT_W]   = {i[0], 2'b00, 5'(i + 8)};
            // A neighbour with a large feature but the zero bit set adds nothing.
            f[((i+1)%LANES)*FEAT_W +: FEAT_W] = 8'h7F;
            w[((i+1)%LANES)*WGT_W +: WGT_W]   = 8'h43;
            mag = ACC_W'(3) << (i + 8);
            v.name = $sformatf("sweep_lane%0d", i);
            v.feat = f; v.wgt = w;
            v.exp_dot = i[0] ? mag : -mag;
            tbl.push_back(v);
        end

        for (int i = 0; i < tbl.size(); i++)
            send_beat(1'b1, 1'b1, tbl[i].feat, tbl[i].wgt, 1'b1, {1'b0, tbl[i].exp_dot});
        idle();
        drain("table_drain");

        // Latency on an idle pipe
        wait_cycles(3);
        send_beat(1'b1, 1'b1, rep_f(8'd1), rep_w(8'h00), 1'b1, {1'b0, 32'd16});
        idle();
        k = 0;
        while (!bus.ovalid && k < 30) begin
            @(negedge clock);
            k++;
        end
        check("latency", cyc - accept_cyc, LAT);
        @(posedge clock); #1;
        drain("latency_drain");

        // Three-beat group then an implicit-start single beat
        send_beat(1'b1, 1'b0, rep_f(8'd1), rep_w(8'h00), 1'b0, '0);
        send_beat(1'b0, 1'b0, rep_f(8'd3), rep_w(8'h82), 1'b0, '0);
        send_beat(1'b0, 1'b1, rep_f(8'd2), rep_w(8'h00), 1'b1, {1'b0, 32'hFFFFFF70});
        f = '0; f[0 +: FEAT_W] = 8'd7;
        send_beat(1'b0, 1'b1, f, rep_w(8'h00), 1'b1, {1'b0, 32'd7});
        idle();
        drain("group_drain");

        // Overflow wraps and is sticky, next group clears it
        f = '0; w = '0;
        f[0 +: FEAT_W] = 8'd64; w[0 +: WGT_W] = 8'h18;
        send_beat(1'b1, 1'b0, f, w, 1'b0, '0);
        send_beat(1'b0, 1'b1, f, w, 1'b1, {1'b1, 32'h80000000});
        send_beat(1'b1, 1'b1, rep_f(8'd1), rep_w(8'h00), 1'b1, {1'b0, 32'd16});
        idle();
        drain("ovf_drain");

        // Backpressure mid-stream
        out0 = n_out;
        fork
            begin
                for (int i = 0; i < 8; i++) send_beat(1'b1, 1'b1, rand_f(), rand_w(), 1'b0, '0);
                idle();
            end
            begin
                wait_cycles(7);
                bus.iready = 1'b0;
                wait_cycles(4);
                bus.iready = 1'b1;
            end
        join
        drain("bp_drain");
        check("bp_count", n_out - out0, 8);

        // Randomized groups with random backpressure and gaps
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 80; i++) begin
                    send_beat(($urandom_range(0, 3) == 0), (i == 79) || ($urandom_range(0, 2) == 0),
                              rand_f(), rand_w(), 1'b0, '0);
                    if ($urandom_range(0, 3) == 0) begin
                        idle();
                        wait_cycles($urandom_range(1, 3));
                    end
                end
                idle();
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    bus.iready = ($urandom_range(0, 3) != 0);
                    wait_cycles(1);
                end
                bus.iready = 1'b1;
            end
        join
        drain("rand_drain");

        // Reset in the middle of a stream
        for (int i = 0; i < 8; i++) send_beat(1'b1, 1'b1, rand_f(), rand_w(), 1'b0, '0);
        idle();
        #3 resetn = 1'b0;
        #1;
        check("midrst_ovalid", bus.ovalid, 0);
        check("midrst_dot", bus.dot_accum, 0);
        check("midrst_ovf", bus.ovf, 0);
        check("midrst_oready", bus.oready, 1);
        exp_q.delete();
        model_done = 1'b1;
        model_acc  = '0;
        model_ovf  = 1'b0;
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        @(posedge clock);
        #1;
        // First beat after reset carries ifirst=0 yet must open a new group.
        send_beat(1'b0, 1'b0, rand_f(), rand_w(), 1'b0, '0);
        send_beat(1'b0, 1'b0, rand_f(), rand_w(), 1'b0, '0);
        send_beat(1'b0, 1'b1, rand_f(), rand_w(), 1'b0, '0);
        idle();
        drain("post_reset_drain");
        wait_cycles(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/shift_dot_accum.md
# shift_dot_accum

Parametrised, pipelined power-of-two-weight dot-product engine for the PE array. Each accepted beat carries LANES signed features and LANES shift-encoded weights. Each lane's term is ±(feature << shift) or zero. Terms are summed through a registered adder tree and accumulated across a multi-beat group delimited by first/last flags. Adds full valid/ready backpressure and an overflow flag.

## Interface
- LANES, 16, lane count; power of two, ≥2
- FEAT_W, 8, signed feature width per lane
- WGT_W, 8, weight code width; bit WGT_W-1 = negate, bit WGT_W-2 = zero, bits SHIFT_W-1:0 = shift
- SHIFT_W, 5, shift field width; SHIFT_W ≤ WGT_W-2
- ACC_W, 32, term, tree and accumulator width (two's complement)
- clock  in  1  single clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- ivalid  in  1  upstream beat valid
- oready  out  1  block can accept a beat this cycle
- ifirst  in  1  beat starts a new group
- ilast  in  1  beat ends the group; its result is emitted
- feature_values  in  LANES*FEAT_W  lane i at [i*FEAT_W +: FEAT_W]
- filter_values  in  LANES*WGT_W  lane i at [i*WGT_W +: WGT_W]
- ovalid  out  1  dot_accum valid
- iready  in  1  downstream accepts result
- dot_accum  out  ACC_W  group result
- ovf  out  1  signed overflow occurred in accumulator during this group

## Operation
- Global enable: en = ~ovalid | iready; oready = en. A beat is accepted when ivalid & oready. All pipeline registers, including valid bits, hold when en=0.
- Stage D (decode, registered):
  - Per lane, sign-extend the feature to ACC_W.
  - Force the term to 0 if the zero bit is set.
  - Shift left by the shift field, truncating to ACC_W.
  - Two's-complement negate if the negate bit is set.
  - Lanes are fully independent; no lane may use another lane's shift result.
- Tree: log2(LANES) registered pairwise adder levels. Each add is modulo 2^ACC_W and carries valid, first and last sideband bits.
- Accumulator stage:
  - On a valid tree output, acc = start ? sum : acc + sum, where start = first | group_done.
  - group_done is set after a last beat is accumulated and cleared on the next valid beat. A beat following a last beat always starts a new group, even if ifirst=0.
  - ovf is cleared at group start and set sticky when the signed add overflows. The add itself wraps; it never saturates.
- ovalid rises with the accumulator update for a last beat. It drops on the next en cycle unless another last beat is accumulated in that cycle.
- ifirst & ilast on the same beat forms a single-beat group.
- Non-last beats update acc but do not assert ovalid.

## Timing
- Reset (resetn=0, asynchronous):
  - All valid bits 0, acc = 0, dot_accum = 0, ovf = 0, ovalid = 0, group_done = 1.
  - oready = 1 once the reset state is applied.
- Latency: beat accepted at edge t → ovalid at edge t + log2(LANES) + 2 with no stall (6 cycles for LANES=16).
- Throughput: one beat per cycle while iready=1.
- Backpressure: ovalid=1 & iready=0 freezes the whole pipe. dot_accum and ovf hold stable; no beat is lost or duplicated.
- Reset mid-group: all in-flight beats are discarded. The first beat after reset starts a new group.
- dot_accum and ovf are registered outputs, stable while ovalid=1.

## Test plan
- All 16 lanes: feature 1, weight 0x00, single-beat group (ifirst=ilast=1) → ovalid 6 cycles later, dot_accum = 16, ovf = 0.
- All lanes: feature 3, weight 0x82 (negate, shift 2) → dot_accum = -192 (0xFFFFFF40). Repeat with weight 0x42 (zero bit) → 0.
- Lane isolation: only lane 7 has feature 5, weight 0x01; lane 0 has feature 9, weight 0x80, all others zero → dot_accum = 10 - 9 = 1. Sweep each lane alone with a distinct shift and check exact values.
- Three-beat group (first, mid, last) with per-beat sums 16, -192, 32 → a single ovalid pulse with -144; no ovalid on the first two beats. A following beat with ifirst=0, ilast=1 and sum 7 → result 7.
- Overflow: two-beat group where each beat is lane 0 feature 64, weight 0x18 (shift 24), sum 2^30 → dot_accum = 0x80000000 (wrapped), ovf = 1. The next group clears ovf.
- Backpressure and reset: stream 8 single-beat groups, hold iready=0 for 4 cycles mid-stream → all 8 results delivered in order, each exactly once. Assert resetn low mid-stream → ovalid=0 and dot_accum=0 immediately; the post-reset group is correct.
